// File: rtl/mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : mmio_responder
// Purpose  : MMIO target for the upper half of the 9-bit data-memory space:
//            LED, switch, prescaled timer and HEX-display registers.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_responder #(
  parameter int PRESCALE    = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  input  logic [9:0]  sw_in,
  output logic        mmio_sel,
  output logic [15:0] read_data,
  output logic [7:0]  ledr,
  output logic [15:0] hex_value,
  output logic        timer_tick
);

  localparam logic [1:0]  c_mread       = 2'b01;
  localparam logic [1:0]  c_mwrite      = 2'b10;
  localparam logic [8:0]  c_addr_led    = 9'h100;
  localparam logic [8:0]  c_addr_sw     = 9'h140;
  localparam logic [8:0]  c_addr_timer  = 9'h180;
  localparam logic [8:0]  c_addr_hex    = 9'h1C0;
  localparam logic [15:0] c_presc_last  = 16'(PRESCALE - 1);

  logic [7:0]  led_q,   led_d;
  logic [15:0] hex_q,   hex_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] rdata_q, rdata_d;
  logic        tick_q,  tick_d;
  logic [9:0]  sync_q [SYNC_STAGES];

  logic        w_rd;
  logic        w_wr;
  logic        w_wrap;
  logic        w_timer_wr;
  logic [15:0] w_rd_mux;

  assign mmio_sel = mem_addr[8];
  assign w_rd     = mmio_sel && (mem_cmd == c_mread);
  assign w_wr     = mmio_sel && (mem_cmd == c_mwrite);
  assign w_wrap   = (presc_q == c_presc_last);
  assign w_timer_wr = w_wr && (mem_addr == c_addr_timer);

  // Switch synchronizer: stage 0 samples the raw pins, later stages re-time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q[0] <= '0;
    end else begin
      sync_q[0] <= sw_in;
    end
  end

  for (genvar g = 1; g < SYNC_STAGES; g++) begin : g_sync
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_q[g] <= '0;
      end else begin
        sync_q[g] <= sync_q[g-1];
      end
    end
  end

  always_comb begin
    w_rd_mux = 16'h0000;
    case (mem_addr)
      c_addr_led:   w_rd_mux = {8'h00, led_q};
      c_addr_sw:    w_rd_mux = {6'b0, sync_q[SYNC_STAGES-1]};
      c_addr_timer: w_rd_mux = timer_q;
      c_addr_hex:   w_rd_mux = hex_q;
      default:      w_rd_mux = 16'h0000;
    endcase
  end

  always_comb begin
    led_d   = led_q;
    hex_d   = hex_q;
    timer_d = timer_q;
    presc_d = presc_q + 16'd1;
    tick_d  = 1'b0;
    rdata_d = w_rd ? w_rd_mux : 16'h0000;

    if (w_wr && (mem_addr == c_addr_led)) begin
      led_d = write_data[7:0];
    end
    if (w_wr && (mem_addr == c_addr_hex)) begin
      hex_d = write_data;
    end

    // A CPU load of the timer overrides a coincident prescaler wrap.
    if (w_timer_wr) begin
      timer_d = write_data;
      presc_d = 16'h0000;
    end else if (w_wrap) begin
      timer_d = timer_q + 16'd1;
      presc_d = 16'h0000;
      tick_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_q   <= '0;
      hex_q   <= '0;
      timer_q <= '0;
      presc_q <= '0;
      rdata_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      led_q   <= led_d;
      hex_q   <= hex_d;
      timer_q <= timer_d;
      presc_q <= presc_d;
      rdata_q <= rdata_d;
      tick_q  <= tick_d;
    end
  end

  assign read_data  = rdata_q;
  assign ledr       = led_q;
  assign hex_value  = hex_q;
  assign timer_tick = tick_q;

endmodule
`default_nettype wire
